// File: rtl/rtx_pkg.sv
// Shared ray-tracing types: Q16.16 fixed point, vectors, colours and the
// ray record that travels through the intersector/reflector loop.
package rtx_pkg;

    localparam int unsigned FP_BITS      = 32;
    localparam int unsigned FP_FRAC      = 16;
    localparam int unsigned FP_VEC3_BITS = 3 * FP_BITS;

    typedef logic signed [FP_BITS-1:0] fp;

    localparam fp FP_ONE = fp'(1 << FP_FRAC);

    typedef struct packed {
        fp x;
        fp y;
        fp z;
    } fp_vec3;

    typedef struct packed {
        fp r;
        fp g;
        fp b;
    } fp_color;

    // Sideband widths used by the loop stages for the default configuration.
    localparam int unsigned RAY_PIX_W   = 17;
    localparam int unsigned RAY_DEPTH_W = 2;

    typedef struct packed {
        fp_vec3                 origin;
        fp_vec3                 dir;
        fp_color                color;
        fp_color                light;
        logic [RAY_PIX_W-1:0]   pixel;
        logic [RAY_DEPTH_W-1:0] depth;
    } trace_ray_t;

    function automatic fp_color color_splat(input fp v);
        return '{r: v, g: v, b: v};
    endfunction

endpackage

// File: rtl/ray_retire_fifo.sv
// First-word-fall-through FIFO holding retired {pixel, light} results.
// Push while full and pop while empty are ignored.
module ray_retire_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr_q];

    // Storage array; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/ray_bounce_scheduler.sv
// Owns the single entry slot of the fixed-latency trace loop: recirculating
// rays first, fresh camera rays otherwise. Finished rays drain through a
// retire FIFO; a credit counter over loop + FIFO keeps that FIFO from
// overflowing since the loop itself can never stall.
module ray_bounce_scheduler
    import rtx_pkg::*;
#(
    parameter int unsigned MAX_BOUNCES  = 4,
    parameter int unsigned MAX_INFLIGHT = 48,
    parameter int unsigned LOOP_LATENCY = 64,
    parameter int unsigned PIX_W        = 17,
    localparam int unsigned DEPTH_W     = (MAX_BOUNCES > 1) ? $clog2(MAX_BOUNCES) : 1,
    localparam int unsigned INF_W       = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic               clk,
    input  logic               rst,
    // Camera rays
    input  logic               cam_valid,
    output logic               cam_ready,
    input  fp_vec3             cam_origin,
    input  fp_vec3             cam_dir,
    input  logic [PIX_W-1:0]   cam_pixel,
    // Loop entry
    output logic               trace_valid,
    output fp_vec3             trace_origin,
    output fp_vec3             trace_dir,
    output fp_color            trace_color,
    output fp_color            trace_light,
    output logic [PIX_W-1:0]   trace_pixel,
    output logic [DEPTH_W-1:0] trace_depth,
    // Loop return
    input  logic               ret_valid,
    input  logic               ret_hit,
    input  fp_vec3             ret_origin,
    input  fp_vec3             ret_dir,
    input  fp_color            ret_color,
    input  fp_color            ret_light,
    input  logic [PIX_W-1:0]   ret_pixel,
    input  logic [DEPTH_W-1:0] ret_depth,
    // Retired pixels
    output logic               px_valid,
    input  logic               px_ready,
    output logic [PIX_W-1:0]   px_pixel,
    output fp_color            px_light,
    // Status
    output logic [INF_W-1:0]   inflight,
    output logic               idle
);

    localparam int unsigned BLANK_W = $clog2(LOOP_LATENCY + 1);
    localparam int unsigned ENTRY_W = PIX_W + FP_VEC3_BITS;
    localparam int unsigned FCNT_W  = $clog2(MAX_INFLIGHT + 1);

    logic [BLANK_W-1:0] blank_q;
    logic [INF_W-1:0]   inflight_q;
    logic               blank, ret_live, depth_can_grow;
    logic               recirc, retire, cam_fire, px_pop;

    logic               trace_valid_q, trace_valid_d;
    fp_vec3             trace_origin_q, trace_origin_d;
    fp_vec3             trace_dir_q, trace_dir_d;
    fp_color            trace_color_q, trace_color_d;
    fp_color            trace_light_q, trace_light_d;
    logic [PIX_W-1:0]   trace_pixel_q, trace_pixel_d;
    logic [DEPTH_W-1:0] trace_depth_q, trace_depth_d;

    logic [ENTRY_W-1:0] fifo_rd_data;
    logic               fifo_full, fifo_empty;
    logic [FCNT_W-1:0]  fifo_count;

    // Returns during blanking are stale rays from before reset: drop them.
    assign blank    = (blank_q != '0);
    assign ret_live = ret_valid & ~blank;

    // Depths at or beyond the last bounce (including unused codes) retire.
    assign depth_can_grow = (32'(ret_depth) + 32'd1) < MAX_BOUNCES;
    assign recirc         = ret_live & ret_hit & depth_can_grow;
    assign retire         = ret_live & ~recirc;

    assign cam_ready = ~blank & ~recirc & (inflight_q < INF_W'(MAX_INFLIGHT));
    assign cam_fire  = cam_valid & cam_ready;
    assign px_valid  = ~fifo_empty;
    assign px_pop    = px_valid & px_ready;

    assign {px_pixel, px_light} = fifo_rd_data;

    assign inflight = inflight_q;
    assign idle     = (inflight_q == '0) & ~blank & (fifo_count == '0);

    assign trace_valid  = trace_valid_q;
    assign trace_origin = trace_origin_q;
    assign trace_dir    = trace_dir_q;
    assign trace_color  = trace_color_q;
    assign trace_light  = trace_light_q;
    assign trace_pixel  = trace_pixel_q;
    assign trace_depth  = trace_depth_q;

    // Post-reset blanking countdown, one loop latency long.
    always_ff @(posedge clk) begin
        if (rst) begin
            blank_q <= BLANK_W'(LOOP_LATENCY);
        end else if (blank) begin
            blank_q <= blank_q - BLANK_W'(1);
        end
    end

    // Credits: taken on camera accept, returned on pixel pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= '0;
        end else begin
            unique case ({cam_fire, px_pop})
                2'b10:   inflight_q <= inflight_q + INF_W'(1);
                2'b01:   inflight_q <= inflight_q - INF_W'(1);
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    // Slot arbitration: recirculation wins, payload holds when idle.
    always_comb begin
        trace_valid_d  = 1'b0;
        trace_origin_d = trace_origin_q;
        trace_dir_d    = trace_dir_q;
        trace_color_d  = trace_color_q;
        trace_light_d  = trace_light_q;
        trace_pixel_d  = trace_pixel_q;
        trace_depth_d  = trace_depth_q;
        if (recirc) begin
            trace_valid_d  = 1'b1;
            trace_origin_d = ret_origin;
            trace_dir_d    = ret_dir;
            trace_color_d  = ret_color;
            trace_light_d  = ret_light;
            trace_pixel_d  = ret_pixel;
            trace_depth_d  = ret_depth + DEPTH_W'(1);
        end else if (cam_fire) begin
            trace_valid_d  = 1'b1;
            trace_origin_d = cam_origin;
            trace_dir_d    = cam_dir;
            trace_color_d  = color_splat(FP_ONE);
            trace_light_d  = '0;
            trace_pixel_d  = cam_pixel;
            trace_depth_d  = '0;
        end
    end

    // Registered loop-entry outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            trace_valid_q  <= 1'b0;
            trace_origin_q <= '0;
            trace_dir_q    <= '0;
            trace_color_q  <= '0;
            trace_light_q  <= '0;
            trace_pixel_q  <= '0;
            trace_depth_q  <= '0;
        end else begin
            trace_valid_q  <= trace_valid_d;
            trace_origin_q <= trace_origin_d;
            trace_dir_q    <= trace_dir_d;
            trace_color_q  <= trace_color_d;
            trace_light_q  <= trace_light_d;
            trace_pixel_q  <= trace_pixel_d;
            trace_depth_q  <= trace_depth_d;
        end
    end

    ray_retire_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (MAX_INFLIGHT)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (retire & ~fifo_full),
        .push_data ({ret_pixel, ret_light}),
        .pop       (px_pop),
        .pop_data  (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule
